dac_playback_ctrl: RTL and testbench

DAC_PLAYBACK_CTRL -- requirements
Module: dac_playback_ctrl

---
 rtl/dac_pkg.sv | 14 +
 rtl/dac_sample_fifo.sv | 56 +++++
 rtl/dac_playback_ctrl.sv | 148 ++++++++++++++
 tb/tb_dac_playback_ctrl.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dac_pkg.sv
// Shared types and constants for the DAC playback controller.
package dac_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PRIME = 2'd1,
    ST_RUN   = 2'd2
  } dac_state_e;

  localparam logic [7:0] DAC_MIDSCALE   = 8'h80;
  localparam int         DAC_FIFO_DEPTH = 16;
  localparam int         DAC_UCNT_W     = 16;

endpackage

// File: rtl/dac_sample_fifo.sv
// First-word-fall-through sample FIFO with occupancy output and synchronous flush.
module dac_sample_fifo
  import dac_pkg::*;
#(
  parameter int DEPTH = DAC_FIFO_DEPTH
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [7:0]               wdata_i,
  output logic [7:0]               rdata_o,
  output logic [$clog2(DEPTH):0]   level_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic          wr_en, rd_en;

  // A push into a full FIFO is only taken when a pop frees the slot in the same cycle.
  assign wr_en = push_i && (!full_o || pop_i) && !flush_i;
  assign rd_en = pop_i && !empty_o && !flush_i;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      level_q <= level_q + {{(LW-1){1'b0}}, wr_en} - {{(LW-1){1'b0}}, rd_en};
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr_en) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign level_o = level_q;
  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);

endmodule

// File: rtl/dac_playback_ctrl.sv
// DAC playback controller: buffers samples, primes, then plays one sample per divider period.
// Optional macro DAC_PLAYBACK_UNDERRUN_CNT_EN adds a saturating 16-bit underrun event counter.
module dac_playback_ctrl
  import dac_pkg::*;
#(
  parameter int FIFO_DEPTH = DAC_FIFO_DEPTH,
  parameter int DIV_W      = 16
) (
  input  logic                          hclk,
  input  logic                          hreset,
  input  logic                          enable,
  input  logic [DIV_W-1:0]              rate_div,
  input  logic [$clog2(FIFO_DEPTH):0]   prime_level,
  input  logic                          clr_status,
  input  logic [7:0]                    s_data,
  input  logic                          s_valid,
  output logic                          s_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          running,
  output logic                          underrun,
  output logic [7:0]                    dac_data,
  output logic                          dac_clk,
`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
  output logic [DAC_UCNT_W-1:0]         underrun_cnt,
`endif
  output dac_state_e                    dbg_state
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  dac_state_e       state_q, state_d;
  logic [DIV_W-1:0] cnt_q, cnt_d, div_q, div_d;
  logic [DIV_W:0]   clk_thresh;
  logic [7:0]       dac_data_q;
  logic             dac_clk_q, dac_clk_d;
  logic             underrun_q, running_q;

  logic [7:0]       fifo_rdata;
  logic [LW-1:0]    fifo_lvl;
  logic             fifo_full, fifo_empty;
  logic             fifo_push, fifo_pop;

  logic [DIV_W-1:0] div_eff;
  logic [LW-1:0]    prime_eff;
  logic             tick, underrun_evt;

  assign div_eff      = (rate_div == '0) ? DIV_W'(1) : rate_div;
  assign prime_eff    = (prime_level == '0) ? LW'(1) : prime_level;
  assign tick         = (state_q == ST_RUN) && (cnt_q == '0);
  assign fifo_pop     = tick && !fifo_empty && enable;
  assign underrun_evt = tick && fifo_empty && enable;
  assign s_ready      = enable && !fifo_full;
  assign fifo_push    = s_valid && s_ready;

  dac_sample_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (hclk),
    .rst_i   (hreset),
    .flush_i (!enable),
    .push_i  (fifo_push),
    .pop_i   (fifo_pop),
    .wdata_i (s_data),
    .rdata_o (fifo_rdata),
    .level_o (fifo_lvl),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // The divider is latched at each tick so a rate change applies from the next period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_d   = div_q;
    if (!enable) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_PRIME;
        ST_PRIME: begin
          cnt_d = '0;
          if (fifo_lvl >= prime_eff) state_d = ST_RUN;
        end
        ST_RUN: begin
          if (underrun_evt) begin
            state_d = ST_PRIME;
            cnt_d   = '0;
          end else if (tick) begin
            div_d = div_eff;
            cnt_d = DIV_W'(1);
          end else begin
            cnt_d = (cnt_q >= div_q) ? '0 : cnt_q + DIV_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // dac_clk is computed from next-state values so the register lines up with cnt_q.
  assign clk_thresh = ({1'b0, div_d} + (DIV_W+1)'(1)) >> 1;
  assign dac_clk_d  = (state_d == ST_RUN) && ({1'b0, cnt_d} >= clk_thresh);

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      div_q      <= DIV_W'(1);
      dac_data_q <= DAC_MIDSCALE;
      dac_clk_q  <= 1'b0;
      underrun_q <= 1'b0;
      running_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      dac_clk_q <= dac_clk_d;
      running_q <= (state_d == ST_RUN);
      if (!enable)       dac_data_q <= DAC_MIDSCALE;
      else if (fifo_pop) dac_data_q <= fifo_rdata;
      if (underrun_evt)    underrun_q <= 1'b1;
      else if (clr_status) underrun_q <= 1'b0;
    end
  end

`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
  logic [DAC_UCNT_W-1:0] ucnt_q;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      ucnt_q <= '0;
    end else if (clr_status) begin
      ucnt_q <= underrun_evt ? DAC_UCNT_W'(1) : '0;
    end else if (underrun_evt && (ucnt_q != '1)) begin
      ucnt_q <= ucnt_q + DAC_UCNT_W'(1);
    end
  end

  assign underrun_cnt = ucnt_q;
`endif

  assign fifo_level = fifo_lvl;
  assign running    = running_q;
  assign underrun   = underrun_q;
  assign dac_data   = dac_data_q;
  assign dac_clk    = dac_clk_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_dac_playback_ctrl.sv
// Self-checking bench for dac_playback_ctrl: scoreboard of pushed samples vs. DAC output.
module tb_dac_playback_ctrl;
  import dac_pkg::*;

  localparam int LW = 5;

  logic          hclk = 1'b0;
  logic          hreset, enable, clr_status, s_valid;
  logic [15:0]   rate_div;
  logic [LW-1:0] prime_level;
  logic [7:0]    s_data;
  logic          s_ready, running, underrun, dac_clk;
  logic [LW-1:0] fifo_level;
  logic [7:0]    dac_data;
  dac_state_e    dbg_state;
`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
  logic [15:0]   underrun_cnt;
`endif

  dac_playback_ctrl #(.FIFO_DEPTH(16), .DIV_W(16)) dut (
    .hclk        (hclk),
    .hreset      (hreset),
    .enable      (enable),
    .rate_div    (rate_div),
    .prime_level (prime_level),
    .clr_status  (clr_status),
    .s_data      (s_data),
    .s_valid     (s_valid),
    .s_ready     (s_ready),
    .fifo_level  (fifo_level),
    .running     (running),
    .underrun    (underrun),
    .dac_data    (dac_data),
    .dac_clk     (dac_clk),
`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
    .underrun_cnt(underrun_cnt),
`endif
    .dbg_state   (dbg_state)
  );

  // clock / reset
  always #5 hclk = ~hclk;

  int cyc = 0;
  always @(posedge hclk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_errors = 0;
  logic [7:0] exp_q[$];
  int exp_d = 3;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // scoreboard: every rising dac_clk presents the next accepted sample
  logic clk_prev = 1'b0;
  bit   have_rise = 1'b0;
  int   last_rise = 0;
  int   rise_cyc = 0;
  always @(negedge hclk) begin
    if (dac_clk && !clk_prev) begin
      check("sb_avail", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) check("dac_data", dac_data, exp_q.pop_front());
      if (have_rise && running) check("dac_period", cyc - last_rise, exp_d + 1);
      have_rise = 1'b1;
      last_rise = cyc;
      rise_cyc  = cyc;
    end
    if (!dac_clk && clk_prev && running)
      check("dac_clk_high", cyc - rise_cyc, (exp_d + 1) - ((exp_d + 1) >> 1));
    if (!running) have_rise = 1'b0;
    clk_prev = dac_clk;
  end

  // driver tasks
  task automatic push(input logic [7:0] d);
    bit acc = 1'b0;
    s_valid = 1'b1;
    s_data  = d;
    for (int i = 0; i < 200 && !acc; i++) begin
      acc = s_ready;
      @(posedge hclk);
    end
    #1;
    s_valid = 1'b0;
    check("push_acc", acc, 1);
    if (acc) exp_q.push_back(d);
  endtask

  task automatic wait_running(input logic lvl, input int budget, input string tag);
    int n = 0;
    @(negedge hclk);
    while (running !== lvl && n < budget) begin
      @(negedge hclk);
      n++;
    end
    check(tag, running, lvl);
  endtask

  task automatic pulse_clr();
    clr_status = 1'b1;
    @(posedge hclk);
    #1;
    clr_status = 1'b0;
    @(negedge hclk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    hreset = 1'b1; enable = 1'b0; clr_status = 1'b0;
    s_valid = 1'b0; s_data = 8'h00; rate_div = 16'd3; prime_level = 5'd4;
    repeat (3) @(negedge hclk);
    check("rst_dac_data", dac_data, 8'h80);
    check("rst_dac_clk", dac_clk, 0);
    check("rst_s_ready", s_ready, 0);
    check("rst_underrun", underrun, 0);
    check("rst_running", running, 0);
    check("rst_level", fifo_level, 0);
    check("rst_state", dbg_state, ST_IDLE);
    @(posedge hclk);
    #1;
    hreset = 1'b0;

    // D=3, prime 4: run starts once four samples are buffered
    exp_d = 3;
    enable = 1'b1;
    #1;
    for (int k = 0; k < 8; k++) begin
      push(8'h10 + 8'(k));
      @(negedge hclk);
      check("prime_run", running, k >= 4);
    end
    wait_running(1'b0, 100, "drain_exit");
    check("ur_flag", underrun, 1);
    check("ur_state", dbg_state, ST_PRIME);
    check("ur_hold", dac_data, 8'h17);
    check("ur_sb_empty", exp_q.size(), 0);
`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
    check("ucnt_1", underrun_cnt, 1);
`endif
    pulse_clr();
    check("clr_underrun", underrun, 0);
`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
    check("clr_ucnt", underrun_cnt, 0);
`endif

    // fill to full with valid held high; the held sample must wait, not overwrite
    prime_level = 5'd16; rate_div = 16'd20; exp_d = 20;
    for (int k = 0; k < 16; k++) push(8'h20 + 8'(k));
    s_valid = 1'b1;
    s_data  = 8'h30;
    @(negedge hclk);
    check("full_level", fifo_level, 16);
    check("full_ready", s_ready, 0);
    @(negedge hclk);
    check("full_level_hold", fifo_level, 16);
    push(8'h30);
    wait_running(1'b0, 600, "full_drain_exit");
    check("full_ur", underrun, 1);
    check("full_last", dac_data, 8'h30);
    check("full_sb_empty", exp_q.size(), 0);

    // rate_div=0 acts as D=1; prime_level=0 acts as 1
    rate_div = 16'd0; prime_level = 5'd0; exp_d = 1;
    for (int k = 0; k < 8; k++) push(8'h40 + 8'(k));
    wait_running(1'b1, 20, "d1_run");
    wait_running(1'b0, 100, "d1_exit");
    check("d1_state", dbg_state, ST_PRIME);
    check("d1_last", dac_data, 8'h47);
    check("d1_sb_empty", exp_q.size(), 0);

    // drop enable mid-run with five samples buffered
    rate_div = 16'd3; prime_level = 5'd4; exp_d = 3;
    for (int k = 0; k < 9; k++) push(8'h50 + 8'(k));
    n = 0;
    @(negedge hclk);
    while (fifo_level !== 5'd5 && n < 100) begin
      @(negedge hclk);
      n++;
    end
    check("dis_level5", fifo_level, 5);
    enable = 1'b0;
    @(negedge hclk);
    check("dis_state", dbg_state, ST_IDLE);
    check("dis_running", running, 0);
    check("dis_level", fifo_level, 0);
    check("dis_dac", dac_data, 8'h80);
    check("dis_ready", s_ready, 0);
    exp_q.delete();

    // one-sample burst, giving the third underrun since the last clear
    rate_div = 16'd1; prime_level = 5'd1; exp_d = 1;
    enable = 1'b1;
    #1;
    push(8'h60);
    wait_running(1'b1, 20, "one_run");
    wait_running(1'b0, 20, "one_exit");
    check("one_ur", underrun, 1);
    check("one_hold", dac_data, 8'h60);
`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
    check("ucnt_3", underrun_cnt, 3);
`endif
    pulse_clr();
    check("clr2_underrun", underrun, 0);
`ifdef DAC_PLAYBACK_UNDERRUN_CNT_EN
    check("clr2_ucnt", underrun_cnt, 0);
`endif

    // reset while playing discards everything immediately
    rate_div = 16'd3; prime_level = 5'd2; exp_d = 3;
    push(8'h70); push(8'h71); push(8'h72);
    wait_running(1'b1, 20, "rst_mid_run");
    @(negedge hclk);
    #2;
    hreset = 1'b1;
    #1;
    check("rmid_level", fifo_level, 0);
    check("rmid_dac", dac_data, 8'h80);
    check("rmid_running", running, 0);
    check("rmid_dac_clk", dac_clk, 0);
    check("rmid_state", dbg_state, ST_IDLE);
    exp_q.delete();
    enable = 1'b0;
    @(posedge hclk);
    #1;
    hreset = 1'b0;
    @(negedge hclk);
    check("rmid_post_level", fifo_level, 0);
    check("rmid_post_ur", underrun, 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
